// File: rtl/io_input_cond.sv
// -----------------------------------------------------------------------------
// io_input_cond
//
// Multi-channel input conditioner for board buttons and switches. Each channel
// has its own synchroniser, polarity normalisation, debounce FSM, registered
// level, and one-cycle press/release pulses. Channels share nothing but the
// clock and the reset.
//
// Optional feature (macro IO_INPUT_COND_REPEAT_EN):
//   While a channel is held, o_press and o_repeat pulse together first after
//   REPEAT_DELAY_CYCLES, then every REPEAT_PERIOD_CYCLES. Without the macro,
//   o_repeat is tied to 0 and the REPEAT_* parameters have no effect.
//
// Parameters:
//   N_CH                 number of independent channels
//   SYNC_STAGES          synchroniser depth, 2..4
//   STABLE_CYCLES        consecutive matching clocks needed to flip the level (>= 1)
//   ACTIVE_LOW           1: raw 0 means pressed; 0: raw 1 means pressed
//   REPEAT_DELAY_CYCLES  hold time from the press to the first repeat
//   REPEAT_PERIOD_CYCLES interval between the later repeats
//
// Ports:
//   i_clk        system clock
//   i_rst        asynchronous active-high reset
//   i_in         raw asynchronous pin inputs
//   o_level      debounced state, 1 = pressed regardless of ACTIVE_LOW
//   o_press      1-cycle pulse on a debounced press, or on a repeat
//   o_release    1-cycle pulse on a debounced release
//   o_repeat     1-cycle pulse alongside o_press when that press is a repeat
//   o_any_event  OR of all o_press|o_release bits, in the same cycle
//
// Latency: a raw change first sampled at edge k shows on o_level and on the
// pulse outputs at edge k + SYNC_STAGES + STABLE_CYCLES - 1.
// -----------------------------------------------------------------------------
module io_input_cond #(
    parameter int N_CH                 = 4,
    parameter int SYNC_STAGES          = 2,
    parameter int STABLE_CYCLES        = 2000000,
    parameter int ACTIVE_LOW           = 1,
    parameter int REPEAT_DELAY_CYCLES  = 25000000,
    parameter int REPEAT_PERIOD_CYCLES = 5000000
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic [N_CH-1:0] i_in,
    output logic [N_CH-1:0] o_level,
    output logic [N_CH-1:0] o_press,
    output logic [N_CH-1:0] o_release,
    output logic [N_CH-1:0] o_repeat,
    output logic            o_any_event
);

    localparam int MAX_AB = (STABLE_CYCLES > REPEAT_DELAY_CYCLES) ? STABLE_CYCLES
                                                                   : REPEAT_DELAY_CYCLES;
    localparam int MAX_CNT = (MAX_AB > REPEAT_PERIOD_CYCLES) ? MAX_AB : REPEAT_PERIOD_CYCLES;
    localparam int CW = $clog2(MAX_CNT + 1);

    // Raw level that means "not pressed"; the synchroniser resets to it so that
    // reset release never looks like an edge.
    localparam logic INACTIVE = (ACTIVE_LOW != 0);

    localparam logic [CW-1:0] STABLE_LAST = CW'(STABLE_CYCLES - 1);

    typedef enum logic [1:0] {
        REL       = 2'd0,
        REL_WAIT  = 2'd1,
        HELD      = 2'd2,
        HELD_WAIT = 2'd3
    } state_t;

    logic [N_CH-1:0][SYNC_STAGES-1:0] sync_q;
    logic [N_CH-1:0]                  s;

    state_t          state_q [N_CH];
    state_t          state_d [N_CH];
    logic [CW-1:0]   cnt_q   [N_CH];
    logic [CW-1:0]   cnt_d   [N_CH];
    logic [N_CH-1:0] press_d;
    logic [N_CH-1:0] release_d;

    // -------------------------------------------------------------------------
    // Synchroniser and polarity normalisation: s = 1 always means pressed.
    // -------------------------------------------------------------------------
    // NOTE: every clocked process uses non-blocking assignments so that all
    // flops sample their inputs from the same edge, independent of order.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sync_q <= {N_CH{{SYNC_STAGES{INACTIVE}}}};
        end else begin
            for (int c = 0; c < N_CH; c++) begin
                sync_q[c] <= {sync_q[c][SYNC_STAGES-2:0], i_in[c]};
            end
        end
    end

    always_comb begin
        for (int c = 0; c < N_CH; c++) begin
            s[c] = sync_q[c][SYNC_STAGES-1] ^ INACTIVE;
        end
    end

`ifdef IO_INPUT_COND_REPEAT_EN
    logic [CW-1:0]   rcnt_q [N_CH];
    logic [CW-1:0]   rcnt_d [N_CH];
    logic [N_CH-1:0] rphase_q;   // 0: waiting for the first repeat, 1: periodic
    logic [N_CH-1:0] rphase_d;
    logic [N_CH-1:0] repeat_d;
`endif

    // -------------------------------------------------------------------------
    // Debounce FSM, next-state logic. cnt counts matching cycles already seen,
    // so the level flips on the STABLE_CYCLES-th consecutive matching cycle.
    // -------------------------------------------------------------------------
    // NOTE: every variable gets a default at the top of the block; without it
    // a path that skips an assignment would infer a latch.
    always_comb begin
        press_d   = '0;
        release_d = '0;
`ifdef IO_INPUT_COND_REPEAT_EN
        repeat_d  = '0;
        rphase_d  = rphase_q;
`endif
        for (int c = 0; c < N_CH; c++) begin
            state_d[c] = state_q[c];
            cnt_d[c]   = cnt_q[c];
`ifdef IO_INPUT_COND_REPEAT_EN
            rcnt_d[c]  = rcnt_q[c];
`endif
            unique case (state_q[c])
                REL: begin
                    if (s[c]) begin
                        if (STABLE_CYCLES == 1) begin
                            state_d[c] = HELD;
                            press_d[c] = 1'b1;
                            cnt_d[c]   = '0;
                        end else begin
                            state_d[c] = REL_WAIT;
                            cnt_d[c]   = CW'(1);
                        end
                    end
                end
                REL_WAIT: begin
                    if (!s[c]) begin
                        state_d[c] = REL;
                        cnt_d[c]   = '0;
                    end else if (cnt_q[c] >= STABLE_LAST) begin
                        state_d[c] = HELD;
                        press_d[c] = 1'b1;
                        cnt_d[c]   = '0;
                    end else begin
                        cnt_d[c] = cnt_q[c] + CW'(1);
                    end
                end
                HELD: begin
                    if (!s[c]) begin
                        if (STABLE_CYCLES == 1) begin
                            state_d[c]   = REL;
                            release_d[c] = 1'b1;
                            cnt_d[c]     = '0;
                        end else begin
                            state_d[c] = HELD_WAIT;
                            cnt_d[c]   = CW'(1);
                        end
                    end
                end
                HELD_WAIT: begin
                    if (s[c]) begin
                        state_d[c] = HELD;
                        cnt_d[c]   = '0;
                    end else if (cnt_q[c] >= STABLE_LAST) begin
                        state_d[c]   = REL;
                        release_d[c] = 1'b1;
                        cnt_d[c]     = '0;
                    end else begin
                        cnt_d[c] = cnt_q[c] + CW'(1);
                    end
                end
                default: begin
                    state_d[c] = REL;
                    cnt_d[c]   = '0;
                end
            endcase

`ifdef IO_INPUT_COND_REPEAT_EN
            // Repeat counter: cleared on entering HELD and in REL, frozen in
            // HELD_WAIT, advancing only while the channel stays in HELD. A
            // release only leaves HELD_WAIT (or HELD when STABLE_CYCLES is 1),
            // so it can never coincide with a repeat.
            if (state_d[c] == REL ||
                (state_d[c] == HELD && state_q[c] != HELD && state_q[c] != HELD_WAIT)) begin
                rcnt_d[c]   = '0;
                rphase_d[c] = 1'b0;
            end else if (state_q[c] == HELD && state_d[c] == HELD) begin
                if (rcnt_q[c] == (rphase_q[c] ? CW'(REPEAT_PERIOD_CYCLES - 1)
                                              : CW'(REPEAT_DELAY_CYCLES - 1))) begin
                    press_d[c]  = 1'b1;
                    repeat_d[c] = 1'b1;
                    rcnt_d[c]   = '0;
                    rphase_d[c] = 1'b1;
                end else begin
                    rcnt_d[c] = rcnt_q[c] + CW'(1);
                end
            end
`endif
        end
    end

    // -------------------------------------------------------------------------
    // State, counters and registered outputs.
    // -------------------------------------------------------------------------
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int c = 0; c < N_CH; c++) begin
                state_q[c] <= REL;
                cnt_q[c]   <= '0;
            end
            o_level     <= '0;
            o_press     <= '0;
            o_release   <= '0;
            o_any_event <= 1'b0;
        end else begin
            for (int c = 0; c < N_CH; c++) begin
                state_q[c] <= state_d[c];
                cnt_q[c]   <= cnt_d[c];
                o_level[c] <= (state_d[c] == HELD) || (state_d[c] == HELD_WAIT);
            end
            o_press     <= press_d;
            o_release   <= release_d;
            o_any_event <= |(press_d | release_d);
        end
    end

`ifdef IO_INPUT_COND_REPEAT_EN
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int c = 0; c < N_CH; c++) begin
                rcnt_q[c] <= '0;
            end
            rphase_q <= '0;
            o_repeat <= '0;
        end else begin
            for (int c = 0; c < N_CH; c++) begin
                rcnt_q[c] <= rcnt_d[c];
            end
            rphase_q <= rphase_d;
            o_repeat <= repeat_d;
        end
    end
`else
    assign o_repeat = '0;
`endif

endmodule

// File: tb/tb_io_input_cond.sv
// -----------------------------------------------------------------------------
// tb_io_input_cond
//
// Directed bench for io_input_cond with N_CH=4, SYNC_STAGES=2, STABLE_CYCLES=8,
// REPEAT_DELAY_CYCLES=20, REPEAT_PERIOD_CYCLES=6. The main instance is
// active-low; a second instance with ACTIVE_LOW=0 covers the other polarity.
// Expected events (edge number, pulse masks, level) are queued when stimulus
// is applied; a monitor pops and compares whenever the DUT shows an event.
// -----------------------------------------------------------------------------
module tb_io_input_cond;

    localparam int N_CH       = 4;
    localparam int LAT        = 9;   // SYNC_STAGES + STABLE_CYCLES - 1
    localparam int REP_DELAY  = 20;
    localparam int REP_PERIOD = 6;

    typedef struct {
        int         cycle;
        logic [3:0] press;
        logic [3:0] rel;
        logic [3:0] rep;
        logic [3:0] level;
    } ev_t;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N_CH-1:0] din = 4'hF;
    logic [N_CH-1:0] pol_in = 4'h0;

    logic [N_CH-1:0] level, press, release_p, repeat_p;
    logic            any_event;
    logic [N_CH-1:0] pol_level, pol_press, pol_release, pol_repeat;
    logic            pol_any;

    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    ev_t  sb[$];
    ev_t  mon_ev;
    logic [3:0] exp_level = 4'h0;

    io_input_cond #(
        .N_CH(N_CH), .SYNC_STAGES(2), .STABLE_CYCLES(8), .ACTIVE_LOW(1),
        .REPEAT_DELAY_CYCLES(REP_DELAY), .REPEAT_PERIOD_CYCLES(REP_PERIOD)
    ) u_dut (
        .i_clk(clk), .i_rst(rst), .i_in(din),
        .o_level(level), .o_press(press), .o_release(release_p),
        .o_repeat(repeat_p), .o_any_event(any_event)
    );

    io_input_cond #(
        .N_CH(N_CH), .SYNC_STAGES(2), .STABLE_CYCLES(8), .ACTIVE_LOW(0),
        .REPEAT_DELAY_CYCLES(REP_DELAY), .REPEAT_PERIOD_CYCLES(REP_PERIOD)
    ) u_pol (
        .i_clk(clk), .i_rst(rst), .i_in(pol_in),
        .o_level(pol_level), .o_press(pol_press), .o_release(pol_release),
        .o_repeat(pol_repeat), .o_any_event(pol_any)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) tick(1);
    endtask

    task automatic push_ev(input int c, input logic [3:0] p, input logic [3:0] r,
                           input logic [3:0] rp);
        ev_t e;
        exp_level = (exp_level | (p & ~rp)) & ~r;
        e.cycle = c;
        e.press = p;
        e.rel   = r;
        e.rep   = rp;
        e.level = exp_level;
        sb.push_back(e);
    endtask

    // Press at edge p, release first sampled at edge rk. The channel is still
    // seen as held by the FSM up to edge rk+1, so repeats can land there.
    task automatic push_hold(input logic [3:0] m, input int p, input int rk);
        push_ev(p, m, 4'h0, 4'h0);
`ifdef IO_INPUT_COND_REPEAT_EN
        for (int t = p + REP_DELAY; t <= rk + 1; t += REP_PERIOD) push_ev(t, m, 4'h0, m);
`endif
        push_ev(rk + LAT, 4'h0, m, 4'h0);
    endtask

    // Monitor: sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (rst) begin
            if ((press | release_p | repeat_p) != 4'h0 || any_event) begin
                n_checks++;
                n_fail++;
                $display("FAIL pulse_in_reset: press=%0h rel=%0h rep=%0h any=%0b",
                         press, release_p, repeat_p, any_event);
            end
        end else if ((press | release_p | repeat_p) != 4'h0 || any_event) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_event: edge %0d press=%0h rel=%0h rep=%0h any=%0b expected none",
                         cyc, press, release_p, repeat_p, any_event);
            end else begin
                mon_ev = sb.pop_front();
                check("ev_edge", cyc, mon_ev.cycle);
                check("ev_press", press, mon_ev.press);
                check("ev_release", release_p, mon_ev.rel);
                check("ev_repeat", repeat_p, mon_ev.rep);
                check("ev_level", level, mon_ev.level);
                check("ev_any", any_event, 1);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, p, rk, f, e;

        // Reset state
        tick(3);
        check("rst_level", level, 0);
        check("rst_press", press, 0);
        check("rst_release", release_p, 0);
        check("rst_repeat", repeat_p, 0);
        check("rst_any", any_event, 0);
        #2 rst = 1'b0;
        tick(4);

        // Clean press on channel 0, with the opposite-polarity instance in step
        din[0] = 1'b0;
        pol_in[0] = 1'b1;
        k  = cyc + 1;
        p  = k + LAT;
        rk = k + 40;
        push_hold(4'b0001, p, rk);
        wait_cyc(p - 1);
        check("pol_level_before", pol_level[0], 0);
        wait_cyc(p);
        check("pol_level_after", pol_level[0], 1);
        check("pol_press", pol_press[0], 1);
        wait_cyc(p + 1);
        check("pol_press_one_cycle", pol_press[0], 0);
        check("press_one_cycle", press[0], 0);
        wait_cyc(rk - 1);
        din[0] = 1'b1;
        wait_cyc(rk + LAT + 3);

        // Glitch rejection: 5 low cycles never reach the level
        din[1] = 1'b0;
        tick(5);
        din[1] = 1'b1;
        tick(14);
        check("glitch_level", level[1], 0);

        // Chatter: low 7 (one short), high 1, then low 10
        din[1] = 1'b0;
        tick(7);
        din[1] = 1'b1;
        tick(1);
        din[1] = 1'b0;
        f = cyc + 1;
        push_hold(4'b0010, f + LAT, f + 10);
        tick(10);
        din[1] = 1'b1;
        wait_cyc(f + 10 + LAT + 3);

        // Simultaneous press and release on channels 2 and 3
        din[3:2] = 2'b00;
        k = cyc + 1;
        push_hold(4'b1100, k + LAT, k + 12);
        wait_cyc(k + 11);
        din[3:2] = 2'b11;
        wait_cyc(k + 12 + LAT + 3);

        // Reset mid-debounce: ch2 held (level 1), ch0 at count 5
        din[2] = 1'b0;
        k = cyc + 1;
        push_ev(k + LAT, 4'b0100, 4'h0, 4'h0);
        wait_cyc(k + LAT);
        din[0] = 1'b0;
        k = cyc + 1;
        wait_cyc(k + 6);
        #2 rst = 1'b1;
        exp_level = 4'h0;
        #1;
        check("midrst_level", level, 0);
        check("midrst_press", press, 0);
        check("midrst_any", any_event, 0);
        @(posedge clk);
        #3 rst = 1'b0;
        k = cyc + 1;
        push_hold(4'b0101, k + LAT, k + 14);
        wait_cyc(k + LAT - 1);
        check("postrst_level_wait", level, 0);
        wait_cyc(k + 13);
        din[0] = 1'b1;
        din[2] = 1'b1;
        wait_cyc(k + 14 + LAT + 3);

        // Long hold on channel 0: repeats only when the feature is built in
        din[0] = 1'b0;
        k  = cyc + 1;
        p  = k + LAT;
        rk = p + 60;
        push_hold(4'b0001, p, rk);
        wait_cyc(rk - 1);
        din[0] = 1'b1;
        wait_cyc(rk + LAT + 10);

        check("scoreboard_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
